// File: rtl/if_inst_queue_pkg.sv
// Shared bus widths, reset level and NOP encoding for the fetch-to-decode instruction queue.
package if_inst_queue_pkg;

    localparam int           IFQ_AW         = 32;
    localparam int           IFQ_DW         = 32;
    localparam logic         IFQ_RST_ACTIVE = 1'b0;
    localparam logic [31:0]  IFQ_NOP        = 32'h0000_0000;

endpackage

// File: rtl/if_inst_queue_ptr_ctrl.sv
// Head/tail/count bookkeeping for the instruction queue; flush outranks push and pop.
module ifq_ptr_ctrl #(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          if_valid,
    input  logic          id_stall,
    output logic          push,
    output logic          pop,
    output logic [PW-1:0] head,
    output logic [PW-1:0] tail,
    output logic [PW:0]   count,
    output logic          if_ready,
    output logic          id_valid
);

    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [PW:0]   count_r;

    // Full/empty come from the occupancy count alone, so pointer wrap needs no extra bit.
    always_comb begin
        if_ready = (count_r != FULL_CNT);
        id_valid = (count_r != (PW+1)'(0));
        push     = if_valid & if_ready;
        pop      = id_valid & ~id_stall;
        head     = head_r;
        tail     = tail_r;
        count    = count_r;
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (push) tail_r <= tail_r + PW'(1);
            else      tail_r <= tail_r;
            if (pop)  head_r <= head_r + PW'(1);
            else      head_r <= head_r;
            case ({push, pop})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/if_inst_queue.sv
// Circular {pc, inst} FIFO between fetch and decode with fetch back-pressure.
// Optional stall/bubble performance counters are enabled by defining IFQ_PERF_EN.
module if_inst_queue
    import if_inst_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = IFQ_AW,
    parameter int DW    = IFQ_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     if_valid,
    input  logic [AW-1:0]            if_pc,
    input  logic [DW-1:0]            if_inst,
    output logic                     if_ready,
    input  logic                     id_stall,
    output logic                     id_valid,
    output logic [AW-1:0]            id_pc,
    output logic [DW-1:0]            id_inst,
`ifdef IFQ_PERF_EN
    output logic [31:0]              full_cycles,
    output logic [31:0]              bubble_cycles,
`endif
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);

    logic          push_s;
    logic          pop_s;
    logic [PW-1:0] head_s;
    logic [PW-1:0] tail_s;
    logic [PW:0]   count_s;
    logic          if_ready_s;
    logic          id_valid_s;

    logic [AW-1:0] pc_mem_r   [DEPTH];
    logic [DW-1:0] inst_mem_r [DEPTH];

    ifq_ptr_ctrl #(.DEPTH(DEPTH), .PW(PW)) u_ptr_ctrl (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_valid (if_valid),
        .id_stall (id_stall),
        .push     (push_s),
        .pop      (pop_s),
        .head     (head_s),
        .tail     (tail_s),
        .count    (count_s),
        .if_ready (if_ready_s),
        .id_valid (id_valid_s)
    );

    // Entry storage; a push coinciding with flush is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= '0;
                inst_mem_r[i] <= '0;
            end
        end else if (push_s && !flush) begin
            pc_mem_r[tail_s]   <= if_pc;
            inst_mem_r[tail_s] <= if_inst;
        end else begin
            pc_mem_r[tail_s]   <= pc_mem_r[tail_s];
            inst_mem_r[tail_s] <= inst_mem_r[tail_s];
        end
    end

    // Head entry to decode; an empty queue presents a NOP at pc 0.
    always_comb begin
        if_ready = if_ready_s;
        id_valid = id_valid_s;
        level    = count_s;
        if (id_valid_s) begin
            id_pc   = pc_mem_r[head_s];
            id_inst = inst_mem_r[head_s];
        end else begin
            id_pc   = '0;
            id_inst = DW'(IFQ_NOP);
        end
    end

`ifdef IFQ_PERF_EN
    logic [31:0] full_cycles_r;
    logic [31:0] bubble_cycles_r;

    // Blocked-fetch and starved-decode cycle counters; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_cycles_r   <= 32'd0;
            bubble_cycles_r <= 32'd0;
        end else begin
            if (!if_ready_s && if_valid) full_cycles_r <= full_cycles_r + 32'd1;
            else                         full_cycles_r <= full_cycles_r;
            if (!id_valid_s && !id_stall) bubble_cycles_r <= bubble_cycles_r + 32'd1;
            else                          bubble_cycles_r <= bubble_cycles_r;
        end
    end

    assign full_cycles   = full_cycles_r;
    assign bubble_cycles = bubble_cycles_r;
`endif

endmodule

// File: tb/tb_if_inst_queue.sv
// Directed bench for if_inst_queue: queue-based reference model checked every cycle plus literal pins.
module tb_if_inst_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = 32'd0;
    logic [31:0] if_inst = 32'd0;
    logic        if_ready;
    logic        id_stall = 1'b0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [2:0]  level;
`ifdef IFQ_PERF_EN
    logic [31:0] full_cycles;
    logic [31:0] bubble_cycles;
    int unsigned m_full = 0;
    int unsigned m_bubble = 0;
`endif

    int   n_chk = 0;
    int   n_err = 0;
    ent_t mq[$];
    bit   rec_en = 1'b0;
    logic [31:0] popped[$];

    if_inst_queue #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_ready (if_ready),
        .id_stall (id_stall),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
`ifdef IFQ_PERF_EN
        .full_cycles   (full_cycles),
        .bubble_cycles (bubble_cycles),
`endif
        .level    (level)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h1300_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded queue updated by the accept rules at each clock edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
`ifdef IFQ_PERF_EN
            m_full = 0;
            m_bubble = 0;
`endif
        end else begin
            int sz;
            bit do_pop;
            bit do_push;
            sz = mq.size();
`ifdef IFQ_PERF_EN
            if (sz == DEPTH && if_valid) m_full++;
            if (sz == 0 && !id_stall) m_bubble++;
`endif
            if (flush) begin
                mq.delete();
            end else begin
                do_pop  = (sz > 0) && !id_stall;
                do_push = if_valid && (sz < DEPTH);
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back('{pc: if_pc, inst: if_inst});
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int sz;
        sz = mq.size();
        chk("level", 32'(level), 32'(sz));
        chk("id_valid", 32'(id_valid), 32'(sz != 0));
        chk("if_ready", 32'(if_ready), 32'(sz != DEPTH));
        chk("id_pc", id_pc, (sz != 0) ? mq[0].pc : 32'd0);
        chk("id_inst", id_inst, (sz != 0) ? mq[0].inst : 32'd0);
`ifdef IFQ_PERF_EN
        chk("full_cycles", full_cycles, m_full);
        chk("bubble_cycles", bubble_cycles, m_bubble);
`endif
        if (rec_en && id_valid && !id_stall) popped.push_back(id_pc);
    end

    // One cycle with the given inputs; returns 1 time unit after the edge.
    task automatic drive(input bit v, input logic [31:0] pc, input bit st, input bit fl);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst_of(pc);
        id_stall = st;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int cyc;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_inst", id_inst, 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd1);

        // Fill to DEPTH under a decode stall, then a blocked fifth fetch
        for (int i = 0; i < 4; i++) drive(1'b1, 32'(4 * i), 1'b1, 1'b0);
        chk("fill_level", 32'(level), 32'd4);
        chk("fill_if_ready", 32'(if_ready), 32'd0);
        drive(1'b1, 32'h10, 1'b1, 1'b0);
        chk("full_ignored_level", 32'(level), 32'd4);
        chk("full_ignored_id_pc", id_pc, 32'h0);
        // Pop while full with fetch still asserted: no pass-through
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        chk("full_pop_level", 32'(level), 32'd3);
        chk("full_pop_id_pc", id_pc, 32'h4);
        for (int i = 0; i < 3; i++) drive(1'b0, 32'd0, 1'b0, 1'b0);
        chk("drain_level", 32'(level), 32'd0);

        // Streaming from empty: one entry in flight, head pc advancing by 4
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'(4 * k), 1'b0, 1'b0);
            chk("stream_id_pc", id_pc, 32'(4 * k));
            chk("stream_level", 32'(level), 32'd1);
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0);

        // Wrap: ten entries through random stalls
        n = 0;
        cyc = 0;
        popped.delete();
        rec_en = 1'b1;
        while ((popped.size() < 10) && (cyc < 200)) begin
            bit v;
            v = (n < 10);
            if (v && mq.size() < DEPTH) begin
                drive(1'b1, 32'(4 * n), 1'($urandom_range(0, 1)), 1'b0);
                n++;
            end else begin
                drive(v, 32'(4 * n), 1'($urandom_range(0, 1)), 1'b0);
            end
            cyc++;
        end
        rec_en = 1'b0;
        if (popped.size() < 10) chk("wrap_timeout", 32'(popped.size()), 32'd10);
        for (int i = 0; i < 10; i++)
            chk("wrap_order", (i < popped.size()) ? popped[i] : 32'hdead_beef, 32'(4 * i));
        for (int i = 0; i < 6; i++) drive(1'b0, 32'd0, 1'b0, 1'b0);

        // Flush beats a simultaneous push and pop
        drive(1'b1, 32'h30, 1'b1, 1'b0);
        drive(1'b1, 32'h34, 1'b1, 1'b0);
        drive(1'b1, 32'h38, 1'b1, 1'b0);
        chk("preflush_level", 32'(level), 32'd3);
        drive(1'b1, 32'h40, 1'b0, 1'b1);
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_id_valid", 32'(id_valid), 32'd0);
        drive(1'b1, 32'h80, 1'b1, 1'b0);
        chk("postflush_id_pc", id_pc, 32'h80);
        chk("postflush_level", 32'(level), 32'd1);

        // Asynchronous reset between edges with two entries queued
        drive(1'b1, 32'h84, 1'b1, 1'b0);
        chk("prereset_level", 32'(level), 32'd2);
        #3 rst = 1'b0;
        #1;
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_id_valid", 32'(id_valid), 32'd0);
        chk("arst_id_pc", id_pc, 32'd0);
        chk("arst_if_ready", 32'(if_ready), 32'd1);
`ifdef IFQ_PERF_EN
        chk("arst_full_cycles", full_cycles, 32'd0);
        chk("arst_bubble_cycles", bubble_cycles, 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b1;
        drive(1'b1, 32'h90, 1'b1, 1'b0);
        chk("post_arst_id_pc", id_pc, 32'h90);
        chk("post_arst_level", 32'(level), 32'd1);
        drive(1'b0, 32'd0, 1'b0, 1'b0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/if_inst_queue.md
Name: if_inst_queue

Overview:
- Instruction queue between the fetch stage (PC register plus instruction ROM) and the ID stage.
- Captures each fetched {pc, inst} pair into a small circular FIFO.
- Presents the oldest entry to decode, and decouples decode stalls from fetch.
- Back-pressures fetch via if_ready; the pipeline controller folds if_ready into the pause vector that stops the PC.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, 32, PC width; matches the instruction address bus.
- DW, 32, instruction width; matches the instruction bus.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  discard all entries (branch redirect or exception)
- if_valid  in  1  fetch presents a valid pc/inst this cycle
- if_pc  in  AW  PC of the fetched instruction
- if_inst  in  DW  fetched instruction word
- if_ready  out  1  queue can accept a push this cycle
- id_stall  in  1  decode cannot consume this cycle
- id_valid  out  1  head entry is valid
- id_pc  out  AW  PC of head entry
- id_inst  out  DW  instruction of head entry
- level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst low, asynchronous):
  - head, tail and count are 0.
  - All storage entries are 0.
  - id_valid=0, id_pc=0, id_inst=0, level=0, if_ready=1.
- Push: push = if_valid & if_ready. Entry written at tail; tail increments modulo DEPTH.
- Pop: pop = id_valid & ~id_stall. head increments modulo DEPTH.
- if_ready = (count != DEPTH), combinational from count. There is no pass-through when full, even if a pop occurs that cycle.
- id_valid = (count != 0).
- id_pc and id_inst are read combinationally from the storage entry at head. When empty, they are forced to 0 (NOP, pc 0).
- Latency: a pushed entry is visible on id_* the cycle after the push edge (1 cycle, empty to valid).
- Count update:
  - push only: count+1
  - pop only: count-1
  - push and pop together (count in 1..DEPTH-1): count unchanged, both pointers advance
  - neither: hold
- Full (count==DEPTH): if_ready=0, so an asserted if_valid is ignored. A pop in that cycle lowers count to DEPTH-1, and if_ready rises on the next cycle.
- Empty (count==0): pop is impossible because id_valid=0. id_stall has no effect.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are decided by count only, never by pointer comparison.
- Flush is synchronous and has priority over push and pop in the same cycle:
  - head=tail=count=0 on the next edge.
  - The pushed entry and the popped entry of that cycle are both discarded.
  - Storage contents need not be cleared.
- Reset mid-operation: asynchronous return to the reset state regardless of flush, push or pop. The first push after release is accepted normally.
- level always equals count.

Optional Feature:
- Macro: IFQ_PERF_EN.
- When defined, adds two outputs, both reset to 0 and wrapping at 2^32-1:
  - full_cycles [31:0]: increments each cycle with count==DEPTH and if_valid=1 (fetch blocked).
  - bubble_cycles [31:0]: increments each cycle with count==0 and id_stall=0 (decode starved).
- Flush does not clear either counter.
- When undefined, neither the ports nor the counters exist, and behaviour is otherwise identical.

Decomposition:
- Shared definitions (global defines include): instruction address/data bus widths, reset-active level, NOP encoding 32'h00000000.
- One natural sub-module, ifq_ptr_ctrl: head/tail/count registers plus the push/pop/flush priority logic. The storage array and output muxing stay in the top module.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release → level=0, id_valid=0, id_inst=0, if_ready=1.
- Fill: push pc 0x0,0x4,0x8,0xC with id_stall=1 (DEPTH=4) → level=4, if_ready=0. A 5th if_valid with pc 0x10 is ignored, and id_pc stays 0x0.
- Stream: id_stall=0 and if_valid=1 every cycle from empty, pcs 0x0,0x4,… → after the 1-cycle fill, id_pc advances by 4 each cycle and level stays 1.
- Wrap: push/pop 10 entries with random stalls → id_pc sequence is exactly 0x0..0x24 in order, with no loss or duplication across the pointer wrap.
- Flush: with level=3, assert flush together with a push of pc 0x40 and a pop → next cycle level=0 and id_valid=0. A push of pc 0x80 then appears as the head one cycle later.
- Async reset mid-stream: drop rst between clock edges while level=2 → outputs go to 0 immediately, without waiting for a clock edge. Under IFQ_PERF_EN, the counters also read 0.
